// File: rtl/mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mux_scan_ctrl
// Purpose  : Channel select controller for an 8-way switch multiplexer.
//            Advances the channel from a debounced push button (manual) or a
//            periodic scan timer (auto), skipping channels that are masked
//            off, and registers the selected switch bit.
// Revision : 1.0  initial release
// ============================================================================
module mux_scan_ctrl #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int SCAN_CYCLES     = 5000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] sw,
   input  logic       pba,
   input  logic       auto_mode,
   input  logic [7:0] en_mask,
   output logic [2:0] sel,
   output logic       y,
   output logic       sel_chg,
   output logic       none
);

   localparam int c_DB_W   = $clog2(DEBOUNCE_CYCLES);
   localparam int c_ARM_W  = $clog2(DEBOUNCE_CYCLES + 2);
   localparam int c_SCAN_W = $clog2(SCAN_CYCLES);

   localparam logic [c_DB_W-1:0]   c_DB_LAST   = c_DB_W'(DEBOUNCE_CYCLES - 1);
   // Two extra cycles cover the reset value of the synchroniser flops, which
   // reads as "released" before the real button level has propagated.
   localparam logic [c_ARM_W-1:0]  c_ARM_LAST  = c_ARM_W'(DEBOUNCE_CYCLES + 1);
   localparam logic [c_SCAN_W-1:0] c_SCAN_LAST = c_SCAN_W'(SCAN_CYCLES - 1);

   logic                r_sync1;
   logic                r_sync2;
   logic                r_stable;
   logic [c_DB_W-1:0]   r_db_cnt;
   logic [c_ARM_W-1:0]  r_arm_cnt;
   logic                r_armed;
   logic [c_SCAN_W-1:0] r_timer;

   logic                w_db_done;
   logic                w_press;
   logic                w_tick;
   logic                w_advance;
   logic                w_empty;
   logic [2:0]          w_cand;
   logic [2:0]          w_next;
   logic [2:0]          w_sel_next;

   // Debounced level flips this cycle; only a flip to 0 after arming is a press.
   assign w_db_done = (r_sync2 != r_stable) && (r_db_cnt == c_DB_LAST);
   assign w_press   = w_db_done && !r_sync2 && r_armed;
   assign w_tick    = auto_mode && (r_timer == c_SCAN_LAST);
   assign w_advance = w_press || w_tick;
   assign w_empty   = (en_mask == 8'h00);

   // Two-flop synchroniser for the asynchronous button input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= pba;
         r_sync2 <= r_sync1;
      end
   end

   // Debouncer: accept a new level once it has persisted for DEBOUNCE_CYCLES.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stable <= 1'b1;
         r_db_cnt <= '0;
      end else if (r_sync2 == r_stable) begin
         r_db_cnt <= '0;
      end else if (r_db_cnt == c_DB_LAST) begin
         r_stable <= r_sync2;
         r_db_cnt <= '0;
      end else begin
         r_db_cnt <= r_db_cnt + c_DB_W'(1);
      end
   end

   // Arm press detection only after the button is seen released long enough,
   // so a button held through reset never counts as a press.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_arm_cnt <= '0;
         r_armed   <= 1'b0;
      end else if (!r_sync2) begin
         r_arm_cnt <= '0;
      end else if (r_arm_cnt == c_ARM_LAST) begin
         r_armed   <= 1'b1;
      end else begin
         r_arm_cnt <= r_arm_cnt + c_ARM_W'(1);
      end
   end

   // Scan timer: free-runs in auto mode, restarts on a tick or a press.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_timer <= '0;
      end else if (!auto_mode || w_press || w_tick) begin
         r_timer <= '0;
      end else begin
         r_timer <= r_timer + c_SCAN_W'(1);
      end
   end

   // Next enabled channel above sel with wrap; smallest distance wins.
   always_comb begin
      w_next = sel;
      w_cand = sel;
      for (int k = 7; k >= 1; k--) begin
         w_cand = sel + 3'(k);
         if (en_mask[w_cand]) begin
            w_next = w_cand;
         end
      end
   end

   // Select update: forced move off a disabled channel, else move on an event.
   always_comb begin
      w_sel_next = sel;
      if (!w_empty && (!en_mask[sel] || w_advance)) begin
         w_sel_next = w_next;
      end
   end

   // Output registers; y tracks the channel selected on this same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel     <= 3'd0;
         y       <= 1'b0;
         sel_chg <= 1'b0;
         none    <= 1'b0;
      end else begin
         sel     <= w_sel_next;
         y       <= w_empty ? 1'b0 : sw[w_sel_next];
         sel_chg <= (w_sel_next != sel);
         none    <= w_empty;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_scan_ctrl
// Purpose  : Self-checking bench for mux_scan_ctrl: directed scenarios plus
//            randomized stimulus against a cycle-level behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mux_scan_ctrl;

   localparam int D = 4;
   localparam int S = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] sw = 8'b11110000;
   logic       pba = 1'b1;
   logic       auto_mode = 1'b0;
   logic [7:0] en_mask = 8'hFF;
   logic [2:0] sel;
   logic       y;
   logic       sel_chg;
   logic       none;

   int checks = 0;
   int failures = 0;

   // Model state
   int m_s1, m_s2, m_stable, m_run, m_hi, m_armed, m_timer;
   int m_sel, m_y, m_chg, m_none;

   mux_scan_ctrl #(.DEBOUNCE_CYCLES(D), .SCAN_CYCLES(S)) dut (
      .clk(clk), .rst_n(rst_n), .sw(sw), .pba(pba), .auto_mode(auto_mode),
      .en_mask(en_mask), .sel(sel), .y(y), .sel_chg(sel_chg), .none(none)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int next_ch(input int cur, input logic [7:0] m);
      for (int k = 1; k < 8; k++) begin
         if (m[(cur + k) % 8]) return (cur + k) % 8;
      end
      return cur;
   endfunction

   task automatic model_reset();
      m_s1 = 1; m_s2 = 1; m_stable = 1; m_run = 0; m_hi = 0; m_armed = 0;
      m_timer = 0; m_sel = 0; m_y = 0; m_chg = 0; m_none = 0;
   endtask

   // One clock of behaviour, using the inputs present at the edge.
   task automatic model_step();
      int synced, press, tick, new_sel;
      if (!rst_n) begin
         model_reset();
         return;
      end
      synced = m_s2;
      press  = 0;
      if (synced != m_stable) begin
         if (m_run == D - 1) begin
            press    = (synced == 0 && m_armed == 1) ? 1 : 0;
            m_stable = synced;
            m_run    = 0;
         end else begin
            m_run++;
         end
      end else begin
         m_run = 0;
      end
      if (synced == 1) begin
         if (m_hi == D + 1) m_armed = 1;
         else m_hi++;
      end else begin
         m_hi = 0;
      end
      tick = (auto_mode && m_timer == S - 1) ? 1 : 0;
      if (!auto_mode || press == 1 || tick == 1) m_timer = 0;
      else m_timer++;
      new_sel = m_sel;
      if (en_mask != 8'h00 && (!en_mask[m_sel] || press == 1 || tick == 1))
         new_sel = next_ch(m_sel, en_mask);
      m_chg  = (new_sel != m_sel) ? 1 : 0;
      m_sel  = new_sel;
      m_y    = (en_mask == 8'h00) ? 0 : int'(sw[new_sel]);
      m_none = (en_mask == 8'h00) ? 1 : 0;
      m_s2   = m_s1;
      m_s1   = int'(pba);
   endtask

   task automatic run_cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("sel", 32'(sel), 32'(m_sel));
      check("y", 32'(y), 32'(m_y));
      check("sel_chg", 32'(sel_chg), 32'(m_chg));
      check("none", 32'(none), 32'(m_none));
   endtask

   task automatic press_btn();
      pba = 1'b0;
      repeat (10) run_cycle();
      pba = 1'b1;
      repeat (12) run_cycle();
   endtask

   initial begin
      int n;
      model_reset();
      repeat (3) run_cycle();
      rst_n = 1'b1;
      check("rst_sel", 32'(sel), 0);
      check("rst_y", 32'(y), 0);
      check("rst_none", 32'(none), 0);
      check("rst_chg", 32'(sel_chg), 0);
      repeat (12) run_cycle();

      // Press latency: advance lands on the 2+D-th edge after the fall
      pba = 1'b0;
      repeat (D + 1) run_cycle();
      check("lat_before", 32'(sel), 0);
      run_cycle();
      check("lat_at", 32'(sel), 1);
      check("lat_chg", 32'(sel_chg), 1);
      repeat (4) run_cycle();
      pba = 1'b1;
      repeat (12) run_cycle();
      check("single_adv", 32'(sel), 1);
      repeat (7) press_btn();
      check("wrap", 32'(sel), 0);

      // Short glitch is rejected
      pba = 1'b0;
      repeat (2) run_cycle();
      pba = 1'b1;
      repeat (12) run_cycle();
      check("glitch", 32'(sel), 0);

      // Skip mask
      en_mask = 8'b10100100;
      sw = 8'b00100000;
      run_cycle();
      check("skip_start", 32'(sel), 2);
      check("skip_y2", 32'(y), 0);
      press_btn();
      check("skip_5", 32'(sel), 5);
      check("skip_y5", 32'(y), 1);
      press_btn();
      check("skip_7", 32'(sel), 7);
      check("skip_y7", 32'(y), 0);
      press_btn();
      check("skip_wrap2", 32'(sel), 2);

      // Auto scan cadence and press inside a scan period
      en_mask = 8'hFF;
      auto_mode = 1'b1;
      repeat (S - 1) run_cycle();
      check("auto_hold", 32'(sel), 2);
      run_cycle();
      check("auto_tick", 32'(sel), 3);
      check("auto_chg", 32'(sel_chg), 1);
      pba = 1'b0;
      repeat (D + 1) run_cycle();
      check("auto_pre_press", 32'(sel), 3);
      run_cycle();
      check("auto_press", 32'(sel), 4);
      for (int i = 1; i <= S - 1; i++) begin
         run_cycle();
         if (i == 4) pba = 1'b1;
      end
      check("auto_after_press", 32'(sel), 4);
      run_cycle();
      check("auto_retick", 32'(sel), 5);

      // Forced move and all-masked
      auto_mode = 1'b0;
      en_mask = 8'b00001000;
      run_cycle();
      check("force_to3", 32'(sel), 3);
      en_mask = 8'hFF;
      run_cycle();
      en_mask = 8'hF7;
      run_cycle();
      check("force_to4", 32'(sel), 4);
      check("force_chg", 32'(sel_chg), 1);
      en_mask = 8'h00;
      sw = 8'hFF;
      run_cycle();
      check("empty_none", 32'(none), 1);
      check("empty_y", 32'(y), 0);
      press_btn();
      check("empty_hold", 32'(sel), 4);
      en_mask = 8'h01;
      run_cycle();
      check("restore_sel", 32'(sel), 0);
      check("restore_none", 32'(none), 0);

      // Asynchronous reset mid-scan with button held
      en_mask = 8'hFF;
      sw = 8'b11110000;
      auto_mode = 1'b1;
      n = 0;
      while (sel != 3'd6 && n < 200) begin
         run_cycle();
         n++;
      end
      check("reach_sel6", 32'(sel), 6);
      pba = 1'b0;
      repeat (2) run_cycle();
      rst_n = 1'b0;
      #1;
      model_reset();
      check("async_sel", 32'(sel), 0);
      check("async_y", 32'(y), 0);
      auto_mode = 1'b0;
      repeat (2) run_cycle();
      rst_n = 1'b1;
      repeat (30) run_cycle();
      check("held_after_rst", 32'(sel), 0);
      pba = 1'b1;
      repeat (15) run_cycle();
      press_btn();
      check("press_after_rst", 32'(sel), 1);

      // Randomized phase against the model
      for (int i = 0; i < 1500; i++) begin
         sw = 8'($urandom);
         if ($urandom_range(0, 29) == 0) pba = ~pba;
         if ($urandom_range(0, 59) == 0) begin
            case ($urandom_range(0, 4))
               0:       en_mask = 8'h00;
               1:       en_mask = 8'(1 << $urandom_range(0, 7));
               default: en_mask = 8'($urandom);
            endcase
         end
         if ($urandom_range(0, 99) == 0) auto_mode = ~auto_mode;
         run_cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
